// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 11-bit serialiser.
// Frames go out as {stop, parity, data[7:0], start}, one bit per intx tick.
module uart_transmitter #(
  parameter int DEPTH      = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    intx,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    txd,
  output logic [10:0]             tx_frame,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          have_byte;
  logic          at_boundary;

  assign tx_ready    = fifo_count < FULL;
  assign push        = tx_valid & tx_ready;
  assign have_byte   = fifo_count != '0;
  assign at_boundary = (state == IDLE) | (state == STOP);
  assign pop         = intx & at_boundary & have_byte;
  assign head        = mem[rd_ptr];

  // parity is fixed from the byte at load time
  function automatic logic [10:0] build_frame(input logic [7:0] d);
    logic par;
    par = PARITY_ODD ? ~^d : ^d;
    return {1'b1, par, d, 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      txd      <= 1'b1;
      tx_frame <= 11'h7FF;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (intx) begin
        unique case (state)
          IDLE: begin
            if (have_byte) begin
              shreg    <= head;
              tx_frame <= build_frame(head);
              txd      <= 1'b0;
              tx_busy  <= 1'b1;
              bit_cnt  <= '0;
              state    <= START;
            end
          end
          START: begin
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              txd   <= tx_frame[9];
              state <= PARITY;
            end else begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            txd   <= 1'b1;
            state <= STOP;
          end
          STOP: begin
            tx_done <= 1'b1;
            if (have_byte) begin
              shreg    <= head;
              tx_frame <= build_frame(head);
              txd      <= 1'b0;
              bit_cnt  <= '0;
              state    <= START;
            end else begin
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
